mux_nx1_reg: RTL
================

Name: mux_nx1_reg

Overview:
Parametrised, registered N-to-1 datapath multiplexer with a valid/ready handshake on every input channel and on the output. It is the successor to the fixed 3-input combinational muxes in the datapath. It offers two modes: fixed selection (a `sel` port drives the choice, like the existing muxes) and round-robin arbitration among the valid channels. It is used where several producers (ALU, memory, shift unit) share one writeback or register path and need back-pressure.

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- N, 3, number of input channels; N >= 2.
- SEL_W, 2, width of `sel` and `out_sel`; 2**SEL_W >= N is required.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = fixed select via `sel`; 1 = round-robin over `in_valid`.
- sel  input  SEL_W  channel index used in fixed mode.
- in_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  N  channel k offers data.
- in_ready  output  N  channel k transfers on this cycle when in_valid[k] & in_ready[k].
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds an untaken word.
- out_ready  input  1  the consumer accepts out_data this cycle.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- sel_err  output  1  sticky flag: fixed mode saw sel >= N.
- clr_err  input  1  synchronous clear of sel_err.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, sel_err=0, round-robin pointer last=N-1, so channel 0 has first priority.
- load_en = !out_valid | out_ready. The output register accepts a new word only when load_en=1. This gives full throughput of one word per cycle with zero-bubble streaming while out_ready stays high.
- in_ready is combinational. At most one bit of in_ready is high, and it is the granted channel g, with in_ready[g]=load_en. in_ready is all zero when there is no grant.
- Fixed mode (mode=0):
  - If sel < N, then g = sel. A transfer occurs when in_valid[g] & load_en.
  - If sel >= N, there is no grant, in_ready is all 0, and no transfer occurs. sel_err is set on every such cycle. No X is ever driven onto out_data.
- Round-robin mode (mode=1):
  - g is the first k with in_valid[k]=1, searching from last+1 upward and wrapping from N-1 to 0.
  - If no input is valid, there is no grant.
  - `last` is updated to g only on a completed input transfer. A stalled output does not advance the pointer.
- On transfer: out_data <= in_data[g] and out_sel <= g. out_valid <= 1. Latency is one cycle from input handshake to out_valid.
- When out_valid & out_ready and there is no new transfer: out_valid <= 0. out_data and out_sel hold their last values.
- When out_valid & !out_ready: out_data, out_valid and out_sel hold. in_ready is all 0.
- Switching mode takes effect combinationally on the next grant. `last` is kept across mode switches and is updated only in round-robin mode.
- sel_err: set has priority over clr_err when both occur in the same cycle. sel_err is ignored in round-robin mode; no set occurs there.
- Reset asserted mid-stream: the output word is dropped immediately (out_valid=0). The upstream is not acknowledged during reset, and in_ready is forced to 0 while reset_n=0.
- sel and in_data changes while stalled have no effect on the held output.

Test Plan:
1. Reset with N=3, WIDTH=32: out_valid=0, out_data=0, sel_err=0, in_ready=000 while reset_n=0.
2. Fixed mode, sel=1, in_valid=111, in_data ch0/1/2 = 0xA/0xB/0xC, out_ready=1:
   - in_ready=010.
   - Next cycle: out_data=0xB, out_sel=1, out_valid=1.
   - Streaming continues with no bubbles.
3. Fixed mode, sel=3 (invalid): in_ready=000, out_valid stays 0, sel_err=1 and stays 1. Pulsing clr_err with sel=0 clears it. Holding clr_err=1 with sel=3 leaves sel_err=1.
4. Round-robin, in_valid=111, out_ready=1 for 6 cycles: out_sel sequence 0,1,2,0,1,2. With in_valid=101 the sequence is 0,2,0,2.
5. Back-pressure: out_valid=1 with out_data=0xB, out_ready=0 for 3 cycles. out_data stays 0xB, in_ready=000, and the pointer is unchanged. When out_ready returns to 1, the next grant is the channel after 1.
6. Asserting reset_n=0 mid-stream while out_valid=1: out_valid falls to 0 without waiting for a clock edge. After release, round-robin restarts at channel 0.

Source files
------------

// File: rtl/mux_nx1_reg.sv
// mux_nx1_reg: registered N-to-1 mux with valid/ready channels, fixed-select or round-robin grant
module mux_nx1_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 3,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_sel,
    output logic               sel_err,
    input  logic               clr_err
);
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] g;
    logic [SEL_W-1:0] hi_g;
    logic [SEL_W-1:0] lo_g;
    logic             hi_ok;
    logic             lo_ok;
    logic             grant_ok;
    logic             sel_ok;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    assign sel_ok  = {1'b0, sel} < (SEL_W+1)'(N);
    assign load_en = !out_valid || out_ready;
    assign xfer    = |(in_ready & in_valid);
    // Rotating priority: lowest valid channel above last wins, otherwise lowest at or below it
    always_comb begin
        hi_ok = 1'b0;
        lo_ok = 1'b0;
        hi_g  = '0;
        lo_g  = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (in_valid[k] && SEL_W'(k) > last) begin
                hi_ok = 1'b1;
                hi_g  = SEL_W'(k);
            end
            if (in_valid[k] && SEL_W'(k) <= last) begin
                lo_ok = 1'b1;
                lo_g  = SEL_W'(k);
            end
        end
        grant_ok = mode ? (hi_ok || lo_ok) : sel_ok;
        g        = mode ? (hi_ok ? hi_g : lo_g) : sel;
    end
    // One-hot ready for the granted channel and a data mux that never yields X
    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            in_ready[k] = reset_n && grant_ok && load_en && (g == SEL_W'(k));
            sel_data    = (g == SEL_W'(k)) ? in_data[k*WIDTH +: WIDTH] : sel_data;
        end
    end
    // Output register, round-robin pointer and sticky select-error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            sel_err   <= 1'b0;
            last      <= SEL_W'(N-1);
        end else begin
            if (xfer) begin
                out_data  <= sel_data;
                out_sel   <= g;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (xfer && mode)
                last <= g;
            if (!mode && !sel_ok)
                sel_err <= 1'b1;
            else if (clr_err)
                sel_err <= 1'b0;
        end
    end
endmodule
